board_status_scheduler: RTL and testbench

Owns the 10x10 board cell-status store and schedules all access to it. It serves the VGA pixel path one cell read per clock during active video. During blanking it arbitrates read-modify-write shot and ship-placement requests from the player and IA game FSMs. Its output `cell_status_o` feeds the VGA driver's `cell_status` input, and its status-code constants drive the driver's `cell_status_*` code inputs.

---
 rtl/board_status_scheduler_pkg.sv | 58 +++++
 rtl/board_status_scheduler_if.sv | 39 +++
 rtl/board_status_scheduler_arb.sv | 31 +++
 rtl/board_status_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_board_status_scheduler.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/board_status_scheduler_pkg.sv
// Shared constants, types and helpers for the board cell-status scheduler:
// status codes, op codes, FSM states and the read-modify-write merge rule.
package board_pkg;

    localparam int GRID_N  = 10;
    localparam int ST_W    = 5;
    localparam int N_CELLS = GRID_N * GRID_N;
    localparam int ADDR_W  = 7;
    localparam int COORD_W = 4;

    localparam logic [ST_W-1:0] ST_FREE       = ST_W'(0);
    localparam logic [ST_W-1:0] ST_OCC        = ST_W'(1);
    localparam logic [ST_W-1:0] ST_PLAYER_HIT = ST_W'(2);
    localparam logic [ST_W-1:0] ST_IA_HIT     = ST_W'(3);
    localparam logic [ST_W-1:0] ST_BOTH_HIT   = ST_W'(4);

    localparam logic OP_SHOT   = 1'b0;
    localparam logic OP_PLACE  = 1'b1;
    localparam logic ID_PLAYER = 1'b0;
    localparam logic ID_IA     = 1'b1;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_RD,
        S_WR
    } state_t;

    function automatic logic coord_ok(input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] y);
        return (x < COORD_W'(GRID_N)) && (y < COORD_W'(GRID_N));
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(GRID_N) + ADDR_W'(x);
    endfunction

    // A shot that hits a cell already struck by the other side upgrades it to BOTH_HIT.
    function automatic logic [ST_W-1:0] merge_status(input logic [ST_W-1:0] prev,
                                                     input logic            op,
                                                     input logic            id);
        logic [ST_W-1:0] res;
        res = prev;
        if (op == OP_PLACE) begin
            if (prev == ST_FREE) begin
                res = ST_OCC;
            end
        end else if (prev == ST_FREE || prev == ST_OCC) begin
            res = (id == ID_IA) ? ST_IA_HIT : ST_PLAYER_HIT;
        end else if ((id == ID_PLAYER && prev == ST_IA_HIT) ||
                     (id == ID_IA && prev == ST_PLAYER_HIT)) begin
            res = ST_BOTH_HIT;
        end
        return res;
    endfunction

endpackage

// File: rtl/board_status_scheduler_if.sv
// Request/response bundle between the game FSMs (master) and the scheduler (slave).
// Per-requester fields are packed with requester 1 (IA) in the upper slice.
interface board_status_scheduler_if;

    logic [1:0]                  req_valid_in;
    logic [1:0]                  req_ready_o;
    logic [1:0]                  req_op_in;
    logic [7:0]                  req_x_in;
    logic [7:0]                  req_y_in;
    logic                        rsp_valid_o;
    logic                        rsp_id_o;
    logic [board_pkg::ST_W-1:0]  rsp_prev_o;
    logic                        rsp_err_o;

    modport master (
        output req_valid_in,
        output req_op_in,
        output req_x_in,
        output req_y_in,
        input  req_ready_o,
        input  rsp_valid_o,
        input  rsp_id_o,
        input  rsp_prev_o,
        input  rsp_err_o
    );

    modport slave (
        input  req_valid_in,
        input  req_op_in,
        input  req_x_in,
        input  req_y_in,
        output req_ready_o,
        output rsp_valid_o,
        output rsp_id_o,
        output rsp_prev_o,
        output rsp_err_o
    );

endinterface

// File: rtl/board_status_scheduler_arb.sv
// Two-way round-robin arbiter: the requester not served last wins a tie.
// The last-served flop resets to requester 1 so requester 0 starts with priority.
module rr_arbiter2 (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

    logic r_last;

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_last <= 1'b1;
        end else if (i_accept) begin
            r_last <= o_grant[1];
        end
    end

endmodule

// File: rtl/board_status_scheduler.sv
// Owns the 10x10 cell-status array: serves one VGA pixel read per clock in active
// video and runs player/IA read-modify-write requests during blanking.
module board_status_scheduler
    import board_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   vga_enable_in,
    input  logic [COORD_W-1:0]     cell_x_in,
    input  logic [COORD_W-1:0]     cell_y_in,
    output logic [ST_W-1:0]        cell_status_o,
    input  logic                   clear_in,
    output logic                   busy_o,
    board_status_scheduler_if.slave bus
);

    logic [ST_W-1:0]    r_mem [N_CELLS];

    state_t             r_state;
    logic [ADDR_W-1:0]  r_init_cnt;
    logic               r_clear_pend;
    logic               r_busy;
    logic               r_id;
    logic               r_op;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [ST_W-1:0]    r_prev;
    logic               r_err;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [ST_W-1:0]    r_rsp_prev;
    logic               r_rsp_err;
    logic [ST_W-1:0]    r_cell_status;

    logic [1:0]         w_grant;
    logic [1:0]         w_ready;
    logic               w_fire;
    logic               w_fire_id;
    logic               w_pending_clear;
    logic               w_vga_ok;
    logic               w_req_ok;
    logic [ADDR_W-1:0]  w_vga_addr;
    logic [ADDR_W-1:0]  w_req_addr;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [ST_W-1:0]    w_rd_data;
    logic [ST_W-1:0]    w_rd_prev;
    logic               w_rd_err;
    logic [ST_W-1:0]    w_merged;
    logic               w_we;
    logic [ADDR_W-1:0]  w_waddr;
    logic [ST_W-1:0]    w_wdata;

    rr_arbiter2 u_arb (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .i_req    (bus.req_valid_in),
        .i_accept (w_fire),
        .o_grant  (w_grant)
    );

    // A clear arriving in the same cycle as a grant wins, so no request is accepted and lost.
    assign w_pending_clear = r_clear_pend | clear_in;
    assign w_ready   = (r_state == S_IDLE && !vga_enable_in && !w_pending_clear) ? w_grant : 2'b00;
    assign w_fire    = |(w_ready & bus.req_valid_in);
    assign w_fire_id = w_ready[1];

    assign w_vga_ok   = coord_ok(cell_x_in, cell_y_in);
    assign w_req_ok   = coord_ok(r_x, r_y);
    assign w_vga_addr = w_vga_ok ? cell_addr(cell_x_in, cell_y_in) : '0;
    assign w_req_addr = w_req_ok ? cell_addr(r_x, r_y) : '0;

    // Single shared read port: active video always owns it.
    assign w_rd_addr = vga_enable_in ? w_vga_addr : w_req_addr;
    assign w_rd_data = r_mem[w_rd_addr];
    assign w_rd_prev = w_req_ok ? w_rd_data : ST_FREE;
    assign w_rd_err  = !w_req_ok || (r_op == OP_PLACE && w_rd_data != ST_FREE);
    assign w_merged  = merge_status(r_prev, r_op, r_id);

    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = ST_FREE;
        case (r_state)
            S_INIT: begin
                w_we    = 1'b1;
                w_waddr = r_init_cnt;
                w_wdata = ST_FREE;
            end
            S_WR: begin
                w_we    = !r_err;
                w_waddr = w_req_addr;
                w_wdata = w_merged;
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cell_status <= ST_FREE;
        end else if (vga_enable_in) begin
            r_cell_status <= w_vga_ok ? w_rd_data : ST_FREE;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= S_INIT;
            r_init_cnt   <= '0;
            r_clear_pend <= 1'b0;
            r_busy       <= 1'b1;
            r_id         <= 1'b0;
            r_op         <= OP_SHOT;
            r_x          <= '0;
            r_y          <= '0;
            r_prev       <= ST_FREE;
            r_err        <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_prev   <= ST_FREE;
            r_rsp_err    <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_clear_pend <= 1'b0;
                    if (r_init_cnt == ADDR_W'(N_CELLS - 1)) begin
                        r_init_cnt <= '0;
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (clear_in) begin
                        r_state <= S_INIT;
                        r_busy  <= 1'b1;
                    end else if (w_fire) begin
                        r_id    <= w_fire_id;
                        r_op    <= bus.req_op_in[w_fire_id];
                        r_x     <= w_fire_id ? bus.req_x_in[7:4] : bus.req_x_in[3:0];
                        r_y     <= w_fire_id ? bus.req_y_in[7:4] : bus.req_y_in[3:0];
                        r_state <= S_RD;
                        r_busy  <= 1'b1;
                    end
                end
                S_RD: begin
                    if (clear_in) begin
                        r_clear_pend <= 1'b1;
                    end
                    // The response is launched here so it is visible for exactly the WR cycle.
                    if (!vga_enable_in) begin
                        r_prev      <= w_rd_prev;
                        r_err       <= w_rd_err;
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_prev  <= w_rd_prev;
                        r_rsp_err   <= w_rd_err;
                        r_state     <= S_WR;
                    end
                end
                S_WR: begin
                    if (w_pending_clear) begin
                        r_clear_pend <= 1'b0;
                        r_state      <= S_INIT;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_INIT;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign cell_status_o   = r_cell_status;
    assign busy_o          = r_busy;
    assign bus.req_ready_o = w_ready;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_id_o    = r_rsp_id;
    assign bus.rsp_prev_o  = r_rsp_prev;
    assign bus.rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_board_status_scheduler.sv
// Directed bench for board_status_scheduler: requests push expected responses into a
// scoreboard queue that a separate monitor drains whenever rsp_valid_o is seen.
module tb_board_status_scheduler;

    typedef struct {
        logic       id;
        logic [4:0] prev;
        logic       err;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       vgaEn;
    logic [3:0] cellX;
    logic [3:0] cellY;
    logic [4:0] cellStatus;
    logic       clearIn;
    logic       busy;

    int   nChecks;
    int   nFail;
    int   cycle;
    exp_t sbQ[$];

    board_status_scheduler_if bus();

    board_status_scheduler dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .vga_enable_in (vgaEn),
        .cell_x_in     (cellX),
        .cell_y_in     (cellY),
        .cell_status_o (cellStatus),
        .clear_in      (clearIn),
        .busy_o        (busy),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cycle = 0;
        forever begin
            @(posedge clk);
            cycle = cycle + 1;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks = nChecks + 1;
        if (actual != expected) begin
            nFail = nFail + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid_o) begin
                if (sbQ.size() == 0) begin
                    checkOutput("rspUnexpected", 1, 0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("rspId", bus.rsp_id_o, e.id);
                    checkOutput("rspPrev", bus.rsp_prev_o, e.prev);
                    checkOutput("rspErr", bus.rsp_err_o, e.err);
                    checkOutput("rspCycle", cycle, e.cyc);
                end
            end
        end
    end

    task automatic applyStimulus(input logic id, input logic op, input logic [3:0] x,
                                 input logic [3:0] y, input logic [4:0] expPrev,
                                 input logic expErr, input int extraCycles);
        int   n;
        exp_t e;
        @(negedge clk);
        bus.req_valid_in[id]       = 1'b1;
        bus.req_op_in[id]          = op;
        bus.req_x_in[4*id +: 4]    = x;
        bus.req_y_in[4*id +: 4]    = y;
        #1;
        n = 0;
        while (!bus.req_ready_o[id] && n < 50) begin
            @(negedge clk);
            #1;
            n = n + 1;
        end
        checkOutput("reqReady", bus.req_ready_o[id], 1);
        @(posedge clk);
        #1;
        e.id   = id;
        e.prev = expPrev;
        e.err  = expErr;
        e.cyc  = cycle + 1 + extraCycles;
        sbQ.push_back(e);
        @(negedge clk);
        bus.req_valid_in[id] = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < 40) begin
            @(posedge clk);
            #2;
            n = n + 1;
        end
        checkOutput("rspDrain", sbQ.size(), 0);
        @(posedge clk);
    endtask

    task automatic vgaRead(input logic [3:0] x, input logic [3:0] y, input int expected,
                           input string name);
        @(negedge clk);
        vgaEn = 1'b1;
        cellX = x;
        cellY = y;
        @(negedge clk);
        checkOutput(name, cellStatus, expected);
        vgaEn = 1'b0;
    endtask

    task automatic countBusy(input int expected, input string name);
        int n;
        n = 0;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n = n + 1;
            if (!busy) break;
        end
        checkOutput(name, n, expected);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         n;
        int         accCycle;
        int         lastAcc;
        exp_t       e;
        logic [1:0] expGrant [4];
        logic [4:0] expPrevAlt [4];
        logic [3:0] pixX [5];
        logic [3:0] pixY [5];
        int         pixExp [5];

        nChecks = 0;
        nFail   = 0;
        rst     = 1'b1;
        vgaEn   = 1'b0;
        cellX   = '0;
        cellY   = '0;
        clearIn = 1'b0;
        bus.req_valid_in = '0;
        bus.req_op_in    = '0;
        bus.req_x_in     = '0;
        bus.req_y_in     = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetCellStatus", cellStatus, 0);
        checkOutput("resetReady", bus.req_ready_o, 0);
        checkOutput("resetRspValid", bus.rsp_valid_o, 0);
        checkOutput("resetRspId", bus.rsp_id_o, 0);
        checkOutput("resetRspPrev", bus.rsp_prev_o, 0);
        checkOutput("resetRspErr", bus.rsp_err_o, 0);
        checkOutput("resetBusy", busy, 1);

        @(negedge clk);
        rst = 1'b0;
        countBusy(100, "initBusyCycles");

        $display("[TB] VGA read after init");
        vgaRead(4'd3, 4'd4, 0, "vgaInit34");

        $display("[TB] player PLACE (2,5)");
        applyStimulus(1'b0, 1'b1, 4'd2, 4'd5, 5'd0, 1'b0, 0);
        waitDrain();
        vgaRead(4'd2, 4'd5, 1, "vgaAfterPlace");

        $display("[TB] IA SHOT then player SHOT on (2,5)");
        applyStimulus(1'b1, 1'b0, 4'd2, 4'd5, 5'd1, 1'b0, 0);
        waitDrain();
        vgaRead(4'd2, 4'd5, 3, "vgaAfterIaShot");
        applyStimulus(1'b0, 1'b0, 4'd2, 4'd5, 5'd3, 1'b0, 0);
        waitDrain();
        vgaRead(4'd2, 4'd5, 4, "vgaAfterBothShot");

        $display("[TB] IA PLACE on occupied cell");
        applyStimulus(1'b1, 1'b1, 4'd2, 4'd5, 5'd4, 1'b1, 0);
        waitDrain();
        vgaRead(4'd2, 4'd5, 4, "vgaAfterBadPlace");

        $display("[TB] both requesters continuously valid");
        expGrant[0] = 2'b01; expPrevAlt[0] = 5'd0;
        expGrant[1] = 2'b10; expPrevAlt[1] = 5'd0;
        expGrant[2] = 2'b01; expPrevAlt[2] = 5'd2;
        expGrant[3] = 2'b10; expPrevAlt[3] = 5'd3;
        @(negedge clk);
        bus.req_valid_in = 2'b11;
        bus.req_op_in    = 2'b00;
        bus.req_x_in     = {4'd9, 4'd0};
        bus.req_y_in     = {4'd9, 4'd0};
        lastAcc = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n = 0;
            while (bus.req_ready_o == 2'b00 && n < 20) begin
                @(negedge clk);
                #1;
                n = n + 1;
            end
            checkOutput("altGrant", bus.req_ready_o, expGrant[k]);
            @(posedge clk);
            #1;
            accCycle = cycle;
            e.id   = expGrant[k][1];
            e.prev = expPrevAlt[k];
            e.err  = 1'b0;
            e.cyc  = accCycle + 1;
            sbQ.push_back(e);
            if (k > 0) begin
                checkOutput("altSpacing", accCycle - lastAcc, 3);
            end
            lastAcc = accCycle;
            @(negedge clk);
        end
        bus.req_valid_in = 2'b00;
        waitDrain();
        vgaRead(4'd0, 4'd0, 2, "vgaAlt00");
        vgaRead(4'd9, 4'd9, 3, "vgaAlt99");

        $display("[TB] active video stalls RD for 5 cycles");
        pixX[0] = 4'd0;  pixY[0] = 4'd0; pixExp[0] = 2;
        pixX[1] = 4'd9;  pixY[1] = 4'd9; pixExp[1] = 3;
        pixX[2] = 4'd2;  pixY[2] = 4'd5; pixExp[2] = 4;
        pixX[3] = 4'd10; pixY[3] = 4'd0; pixExp[3] = 0;
        pixX[4] = 4'd3;  pixY[4] = 4'd4; pixExp[4] = 0;
        applyStimulus(1'b0, 1'b0, 4'd5, 4'd5, 5'd0, 1'b0, 5);
        vgaEn = 1'b1;
        cellX = pixX[0];
        cellY = pixY[0];
        for (int p = 0; p < 5; p++) begin
            @(negedge clk);
            checkOutput("stallPixel", cellStatus, pixExp[p]);
            if (p < 4) begin
                cellX = pixX[p+1];
                cellY = pixY[p+1];
            end
        end
        checkOutput("stallReadyLow", bus.req_ready_o, 0);
        vgaEn = 1'b0;
        waitDrain();
        vgaRead(4'd5, 4'd5, 2, "vgaAfterStall");

        $display("[TB] out-of-range SHOT");
        applyStimulus(1'b1, 1'b0, 4'd10, 4'd0, 5'd0, 1'b1, 0);
        waitDrain();
        vgaRead(4'd0, 4'd0, 2, "vgaOorKeep00");
        vgaRead(4'd0, 4'd1, 0, "vgaOorKeep01");

        $display("[TB] clear during WR");
        applyStimulus(1'b0, 1'b1, 4'd7, 4'd7, 5'd0, 1'b0, 0);
        @(negedge clk);
        clearIn = 1'b1;
        @(negedge clk);
        clearIn = 1'b0;
        checkOutput("busyAfterClear", busy, 1);
        countBusy(100, "clearBusyCycles");
        waitDrain();
        for (int c = 0; c < 100; c++) begin
            vgaRead(4'(c % 10), 4'(c / 10), 0, "vgaCleared");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
